// File: rtl/cpu_pkg.sv
// Shared constants and types for the RV32I core front end.
// Holds the bubble encoding, reset PC default and fetch FSM state type.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry {pc, instr} parking slot for a word that returns while decode is stalled.
// Clear beats load, load beats drain.
module if_hold_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic        drain,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            instr_d = load_instr;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch: owns the PC, keeps one imem request outstanding,
// and feeds the IF/ID register with stall, flush and redirect support.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;

    logic         deliver;
    logic         hold_valid;
    logic         hold_load;
    logic         hold_drain;
    logic [31:0]  hold_pc;
    logic [31:0]  hold_instr;

    // No new request while a word is parked, so delivery and hold can never both be pending.
    assign imem_req  = !rst && (state_q == ISSUE) && !redirect_valid && !hold_valid;
    assign imem_addr = pc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        deliver  = 1'b0;
        case (state_q)
            ISSUE: begin
                if (redirect_valid) begin
                    pc_d = word_align(redirect_pc);
                end else if (imem_req && imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + INSTR_BYTES;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d    = word_align(redirect_pc);
                    state_d = imem_rvalid ? ISSUE : DROP;
                end else if (imem_rvalid) begin
                    deliver = 1'b1;
                    state_d = ISSUE;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_d = word_align(redirect_pc);
                end
                if (imem_rvalid) begin
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = ISSUE;
            end
        endcase
    end

    assign hold_load  = deliver && stall && !flush;
    assign hold_drain = hold_valid && !stall && !flush;

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (flush) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (stall) begin
            ifid_valid_d = ifid_valid_q;
        end else if (hold_valid) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = hold_pc;
            ifid_instr_d = hold_instr;
        end else if (deliver) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = req_pc_q;
            ifid_instr_d = imem_rdata;
        end else begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ISSUE;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    if_hold_buf u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .load       (hold_load),
        .drain      (hold_drain),
        .load_pc    (req_pc_q),
        .load_instr (imem_rdata),
        .valid      (hold_valid),
        .pc         (hold_pc),
        .instr      (hold_instr)
    );

    assign if_id_valid       = ifid_valid_q;
    assign if_id_pc          = ifid_pc_q;
    assign if_id_instruction = ifid_instr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus randomized traffic,
// checked by a program-order scoreboard against what decode consumes.
module tb_instr_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instruction;

   int checkCount = 0;
   int passCount = 0;
   int consumed = 0;
   int respCnt = 0;
   logic [31:0] respAddr = 32'h0;
   logic [31:0] expNextPc = 32'h0;
   logic [31:0] expPcQ[$];
   logic [31:0] expInstrQ[$];

   instr_fetch dut (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .flush             (flush),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_gnt          (imem_gnt),
      .imem_rvalid       (imem_rvalid),
      .imem_rdata        (imem_rdata),
      .if_id_valid       (if_id_valid),
      .if_id_pc          (if_id_pc),
      .if_id_instruction (if_id_instruction)
   );

   // Free-running 10-time-unit clock
   always #5 clk = ~clk;

   // Instruction memory contents: a fixed scramble of the address, never a NOP
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h0C0F_FEE3;
   endfunction

   // One comparison: bump the totals and report any difference
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
   endtask

   task automatic failNow(input string name, input logic [31:0] actual);
      checkCount++;
      $display("[TB] FAIL %s: got %h with nothing expected (t=%0t)", name, actual, $time);
   endtask

   // Reference model reset: everything in flight is gone and the stream restarts
   task automatic restartStream(input logic [31:0] target);
      expPcQ.delete();
      expInstrQ.delete();
      expNextPc = target & ~32'h3;
   endtask

   // One clock of stimulus: decode controls, memory response, and a grant decision.
   // A redirect is always paired with flush, which kills every unconsumed word.
   task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] tgt,
                                input bit gntOk, input int lat);
      @(posedge clk);
      #1;
      stall = st;
      flush = rd;
      redirect_valid = rd;
      redirect_pc = tgt;
      imem_rvalid = 1'b0;
      imem_gnt = 1'b0;
      if (respCnt > 0) begin
         respCnt--;
         if (respCnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata = memWord(respAddr);
         end
      end
      if (rd) restartStream(tgt);
      #1;
      if (imem_req && gntOk) begin
         imem_gnt = 1'b1;
         checkOutput("fetch_addr", imem_addr, expNextPc);
         expPcQ.push_back(expNextPc);
         expInstrQ.push_back(memWord(expNextPc));
         respAddr = imem_addr;
         respCnt = lat;
         expNextPc = expNextPc + 32'd4;
      end
   endtask

   // Monitor: decode consumes IF/ID on every unstalled, unflushed cycle
   always @(negedge clk) begin
      if (!rst && !stall && !flush) begin
         if (if_id_valid) begin
            consumed++;
            if (expPcQ.size() == 0) begin
               failNow("unexpected_instr", if_id_pc);
            end else begin
               checkOutput("ifid_pc", if_id_pc, expPcQ.pop_front());
               checkOutput("ifid_instr", if_id_instruction, expInstrQ.pop_front());
            end
         end else begin
            checkOutput("bubble_instr", if_id_instruction, NOP);
         end
      end
   end

   // Directed scenarios, randomized traffic, then drain and summary
   initial begin
      logic st, rd, gok;
      logic [31:0] tgt;
      int lat;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_req", imem_req, 0);
      checkOutput("rst_addr", imem_addr, 32'h0);
      checkOutput("rst_valid", if_id_valid, 0);
      checkOutput("rst_pc", if_id_pc, 32'h0);
      checkOutput("rst_instr", if_id_instruction, NOP);
      @(negedge clk);
      rst = 1'b0;
      restartStream(32'h0);
      #1;
      checkOutput("req_after_rst", imem_req, 1);

      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("lat_not_yet", if_id_valid, 0);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("lat_valid", if_id_valid, 1);
      checkOutput("lat_pc", if_id_pc, 32'h0);
      checkOutput("lat_instr", if_id_instruction, memWord(32'h0));
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("gap_valid", if_id_valid, 0);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("second_pc", if_id_pc, 32'h4);

      applyStimulus(1, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 1, 1);
         checkOutput("stall_req", imem_req, 0);
      end
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("drain_req", imem_req, 0);
      applyStimulus(0, 0, 0, 1, 2);
      checkOutput("held_valid", if_id_valid, 1);
      checkOutput("held_pc", if_id_pc, 32'h8);

      applyStimulus(0, 1, 32'h103, 1, 1);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("drop_req", imem_req, 0);
      checkOutput("flush_valid", if_id_valid, 0);
      checkOutput("flush_instr", if_id_instruction, NOP);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("redir_addr", imem_addr, 32'h100);

      applyStimulus(0, 1, 32'h200, 1, 1);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("same_cycle_addr", imem_addr, 32'h200);
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 1, 32'hFFFF_FFFC, 1, 1);
      checkOutput("target_pc", if_id_pc, 32'h200);
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 1, 2);
      checkOutput("wrap_addr", imem_addr, 32'h0);
      checkOutput("wrap_prev_pc", if_id_pc, 32'hFFFF_FFFC);

      applyStimulus(0, 0, 0, 1, 1);
      #1;
      rst = 1'b1;
      restartStream(32'h0);
      #1;
      checkOutput("async_req", imem_req, 0);
      checkOutput("async_addr", imem_addr, 32'h0);
      checkOutput("async_valid", if_id_valid, 0);
      checkOutput("async_pc", if_id_pc, 32'h0);
      checkOutput("async_instr", if_id_instruction, NOP);
      #3;
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("post_rst_req", imem_req, 1);
      checkOutput("post_rst_addr", imem_addr, 32'h0);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("stale_ignored", if_id_valid, 0);

      for (int i = 0; i < 3000; i++) begin
         st = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 19) == 0);
         tgt = $urandom;
         if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
         gok = ($urandom_range(0, 9) < 7);
         lat = $urandom_range(1, 3);
         applyStimulus(st, rd, tgt, gok, lat);
      end

      for (int i = 0; i < 60; i++) begin
         if (expPcQ.size() == 0 && respCnt == 0) break;
         applyStimulus(0, 0, 0, 0, 1);
      end
      repeat (2) @(posedge clk);
      #2;
      checkOutput("drain_empty", expPcQ.size(), 0);
      checkOutput("throughput", (consumed > 200) ? 32'd1 : 32'd0, 32'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
